// File: rtl/frame_checker_fifo_if.sv
// Frame-checker bus: raw receive frames in, checked words and error statistics out.
// The slave modport is the checker's view; the master modport is the producer/consumer side.
interface frame_checker_fifo_if #(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 8
);
    localparam int FRAME_W = 1 + DATA_W + ((PARITY_MODE != 0) ? 1 : 0) + STOP_BITS;
    localparam int OCC_W   = $clog2(FIFO_DEPTH) + 1;

    logic [FRAME_W-1:0] frame_in;
    logic               frame_valid;
    logic [DATA_W-1:0]  data_out;
    logic               data_perr;
    logic               data_ferr;
    logic               data_valid;
    logic               data_ready;
    logic [OCC_W-1:0]   fifo_count;
    logic               overrun;
    logic [CNT_W-1:0]   parity_err_cnt;
    logic [CNT_W-1:0]   frame_err_cnt;
    logic [CNT_W-1:0]   overrun_cnt;
    logic               clr_stats;

    modport slave (
        input  frame_in, frame_valid, data_ready, clr_stats,
        output data_out, data_perr, data_ferr, data_valid, fifo_count,
               overrun, parity_err_cnt, frame_err_cnt, overrun_cnt
    );

    modport master (
        output frame_in, frame_valid, data_ready, clr_stats,
        input  data_out, data_perr, data_ferr, data_valid, fifo_count,
               overrun, parity_err_cnt, frame_err_cnt, overrun_cnt
    );
endinterface

// File: rtl/frame_checker_fifo.sv
// UART frame checker: validates start/stop/parity, buffers words in a first-word-fall-through
// FIFO and keeps saturating error statistics with a sticky overrun flag.
module frame_checker_fifo #(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int DROP_BAD    = 0,
    parameter int CNT_W       = 8
) (
    input logic               clk,
    input logic               rst,
    frame_checker_fifo_if.slave bus
);
    localparam int PAR_W   = (PARITY_MODE != 0) ? 1 : 0;
    localparam int FRAME_W = 1 + DATA_W + PAR_W + STOP_BITS;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + 2;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(FIFO_DEPTH);
    localparam bit DROP_EN = (DROP_BAD != 0);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("frame_checker_fifo: DATA_W must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("frame_checker_fifo: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("frame_checker_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("frame_checker_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage p0: combinational frame decode
    logic [DATA_W-1:0] data_p0;
    logic              par_bad_p0;
    logic              perr_p0;
    logic              ferr_p0;

    always_comb begin
        data_p0 = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_p0[i] = bus.frame_in[FRAME_W-2-i];
        end
        case (PARITY_MODE)
            1:       par_bad_p0 = bus.frame_in[STOP_BITS] != (^data_p0);
            2:       par_bad_p0 = bus.frame_in[STOP_BITS] != (~^data_p0);
            default: par_bad_p0 = 1'b0;
        endcase
        ferr_p0 = bus.frame_in[FRAME_W-1] || !(&bus.frame_in[STOP_BITS-1:0]);
        perr_p0 = par_bad_p0 && !ferr_p0;
    end

    // Stage p1: registered check result
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              perr_p1;
    logic              ferr_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p1 <= 1'b0;
        else      vld_p1 <= bus.frame_valid;
    end

    always_ff @(posedge clk) begin
        if (bus.frame_valid) begin
            data_p1 <= data_p0;
            perr_p1 <= perr_p0;
            ferr_p1 <= ferr_p0;
        end
    end

    // Stage p2: FIFO write, pop and statistics
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   count;
    logic               bad_p1;
    logic [DATA_W-1:0]  wdata_p1;
    logic               pop;
    logic               full;
    logic               drop;
    logic               push;
    logic               lost;

    assign bad_p1   = perr_p1 | ferr_p1;
    assign wdata_p1 = bad_p1 ? {DATA_W{1'b0}} : data_p1;
    assign pop      = (count != '0) && bus.data_ready;
    assign full     = (count == FULL_CNT);
    assign drop     = vld_p1 && DROP_EN && bad_p1;
    assign push     = vld_p1 && !drop && (!full || pop);
    assign lost     = vld_p1 && !drop && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {wdata_p1, perr_p1, ferr_p1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    logic [CNT_W-1:0] perr_cnt;
    logic [CNT_W-1:0] ferr_cnt;
    logic [CNT_W-1:0] ovr_cnt;
    logic             ovr_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_cnt <= '0;
            ferr_cnt <= '0;
            ovr_cnt  <= '0;
            ovr_flag <= 1'b0;
        end else if (bus.clr_stats) begin
            perr_cnt <= '0;
            ferr_cnt <= '0;
            ovr_cnt  <= '0;
            ovr_flag <= 1'b0;
        end else begin
            if (vld_p1 && perr_p1) perr_cnt <= sat_inc(perr_cnt);
            if (vld_p1 && ferr_p1) ferr_cnt <= sat_inc(ferr_cnt);
            if (lost) begin
                ovr_cnt  <= sat_inc(ovr_cnt);
                ovr_flag <= 1'b1;
            end
        end
    end

    logic [ENTRY_W-1:0] head;
    assign head = mem[rd_ptr];

    assign bus.data_valid     = (count != '0);
    assign bus.data_out       = bus.data_valid ? head[ENTRY_W-1:2] : {DATA_W{1'b0}};
    assign bus.data_perr      = bus.data_valid & head[1];
    assign bus.data_ferr      = bus.data_valid & head[0];
    assign bus.fifo_count     = count;
    assign bus.overrun        = ovr_flag;
    assign bus.parity_err_cnt = perr_cnt;
    assign bus.frame_err_cnt  = ferr_cnt;
    assign bus.overrun_cnt    = ovr_cnt;
endmodule

// File: tb/tb_frame_checker_fifo.sv
// Bench for frame_checker_fifo: table-driven frames with a scoreboard on the FIFO output,
// plus directed sequences for overrun, full push/pop, stats clear, reset and saturation.
`timescale 1ns/1ps
module tb_frame_checker_fifo;
    logic clk;
    logic rst;

    frame_checker_fifo_if #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4), .CNT_W(8)) bus ();
    frame_checker_fifo_if #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4), .CNT_W(8)) bus_d ();

    frame_checker_fifo #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4),
                         .DROP_BAD(0), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    frame_checker_fifo #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4),
                         .DROP_BAD(1), .CNT_W(8)) dut_drop (.clk(clk), .rst(rst), .bus(bus_d));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    typedef struct {
        logic [10:0] frame;
        logic [7:0]  exp_data;
        logic        exp_perr;
        logic        exp_ferr;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic start,
                                             input logic flip_par, input logic stop);
        logic [10:0] f;
        f[10] = start;
        for (int i = 0; i < 8; i++) f[9-i] = d[i];
        f[1] = (^d) ^ flip_par;
        f[0] = stop;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [10:0] f);
        bus.frame_in    = f;
        bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
    endtask

    task automatic clear_stats();
        bus.clr_stats = 1'b1;
        tick();
        bus.clr_stats = 1'b0;
    endtask

    // Scoreboard: every accepted pop must match the oldest expected entry
    always @(negedge clk) begin
        if (rst && bus.data_valid && bus.data_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got data 0x%0h perr %0b ferr %0b, expected nothing",
                         bus.data_out, bus.data_perr, bus.data_ferr);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("fifo_head", 32'({bus.data_out, bus.data_perr, bus.data_ferr}), 32'(e));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_perr_cnt;
        int exp_ferr_cnt;

        vecs[0] = '{11'h295, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{11'h297, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{11'h294, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{11'h695, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{11'h296, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{mk_frame(8'h00, 1'b0, 1'b0, 1'b1), 8'h00, 1'b0, 1'b0};
        vecs[6] = '{mk_frame(8'hFF, 1'b0, 1'b0, 1'b1), 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{mk_frame(8'h01, 1'b0, 1'b0, 1'b1), 8'h01, 1'b0, 1'b0};
        vecs[8] = '{mk_frame(8'h80, 1'b0, 1'b1, 1'b1), 8'h00, 1'b1, 1'b0};
        vecs[9] = '{mk_frame(8'h3C, 1'b0, 1'b0, 1'b1), 8'h3C, 1'b0, 1'b0};

        bus.frame_in = '0;   bus.frame_valid = 1'b0; bus.data_ready = 1'b0; bus.clr_stats = 1'b0;
        bus_d.frame_in = '0; bus_d.frame_valid = 1'b0; bus_d.data_ready = 1'b0; bus_d.clr_stats = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) tick();
        check("rst_data_valid", 32'(bus.data_valid), 0);
        check("rst_data_out", 32'(bus.data_out), 0);
        check("rst_fifo_count", 32'(bus.fifo_count), 0);
        check("rst_counters", 32'({bus.parity_err_cnt, bus.frame_err_cnt, bus.overrun_cnt}), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        rst = 1'b1;
        tick();

        // Latency: data_valid must appear only after the second edge
        bus.data_ready = 1'b1;
        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        bus.frame_in = 11'h295; bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
        check("lat_valid_n1", 32'(bus.data_valid), 0);
        tick();
        check("lat_valid_n2", 32'(bus.data_valid), 1);
        check("lat_data_n2", 32'(bus.data_out), 'hA5);
        repeat (2) tick();
        check("good_perr_cnt", 32'(bus.parity_err_cnt), 0);
        check("good_ferr_cnt", 32'(bus.frame_err_cnt), 0);

        // Table vectors, back-to-back strobes at full rate
        exp_perr_cnt = 0;
        exp_ferr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
            if (vecs[i].exp_perr) exp_perr_cnt++;
            if (vecs[i].exp_ferr) exp_ferr_cnt++;
            send(vecs[i].frame);
        end
        repeat (4) tick();
        check("tbl_drained", 32'(exp_q.size()), 0);
        check("tbl_perr_cnt", 32'(bus.parity_err_cnt), 32'(exp_perr_cnt));
        check("tbl_ferr_cnt", 32'(bus.frame_err_cnt), 32'(exp_ferr_cnt));

        // DROP_BAD=1 instance: bad frame counted but never stored
        bus_d.frame_in = 11'h297; bus_d.frame_valid = 1'b1;
        tick();
        bus_d.frame_valid = 1'b0;
        repeat (2) tick();
        check("drop_count", 32'(bus_d.fifo_count), 0);
        check("drop_perr_cnt", 32'(bus_d.parity_err_cnt), 1);
        bus_d.frame_in = 11'h295; bus_d.frame_valid = 1'b1;
        tick();
        bus_d.frame_valid = 1'b0;
        repeat (2) tick();
        check("drop_good_count", 32'(bus_d.fifo_count), 1);
        check("drop_good_data", 32'(bus_d.data_out), 'hA5);

        clear_stats();
        check("clr_perr_cnt", 32'(bus.parity_err_cnt), 0);
        check("clr_ferr_cnt", 32'(bus.frame_err_cnt), 0);

        // Overrun: 6 strobes into a 4-deep FIFO with no consumer
        bus.data_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) exp_q.push_back({8'(i * 'h11), 1'b0, 1'b0});
            send(mk_frame(8'(i * 'h11), 1'b0, 1'b0, 1'b1));
        end
        repeat (2) tick();
        check("ovr_fifo_count", 32'(bus.fifo_count), 4);
        check("ovr_flag", 32'(bus.overrun), 1);
        check("ovr_cnt", 32'(bus.overrun_cnt), 2);
        bus.data_ready = 1'b1;
        repeat (4) tick();
        check("ovr_drain_valid", 32'(bus.data_valid), 0);
        check("ovr_drain_queue", 32'(exp_q.size()), 0);

        // Full FIFO with a push and a pop on the same edge
        clear_stats();
        bus.data_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back({8'('hA0 + i), 1'b0, 1'b0});
            send(mk_frame(8'('hA0 + i), 1'b0, 1'b0, 1'b1));
        end
        repeat (2) tick();
        check("full_count", 32'(bus.fifo_count), 4);
        exp_q.push_back({8'hC3, 1'b0, 1'b0});
        send(mk_frame(8'hC3, 1'b0, 1'b0, 1'b1));
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        check("pushpop_count", 32'(bus.fifo_count), 4);
        check("pushpop_overrun", 32'(bus.overrun), 0);
        check("pushpop_ovr_cnt", 32'(bus.overrun_cnt), 0);
        bus.data_ready = 1'b1;
        repeat (4) tick();
        check("pushpop_drained", 32'(exp_q.size()), 0);

        // clr_stats on the same edge as a parity-error update
        exp_q.push_back({8'h00, 1'b1, 1'b0});
        send(11'h297);
        bus.clr_stats = 1'b1;
        tick();
        bus.clr_stats = 1'b0;
        check("clr_wins_perr", 32'(bus.parity_err_cnt), 0);
        repeat (2) tick();
        check("clr_wins_hold", 32'(bus.parity_err_cnt), 0);

        // Reset between a strobe and its push, with one word already buffered
        bus.data_ready = 1'b0;
        send(11'h295);
        repeat (2) tick();
        check("pre_rst_valid", 32'(bus.data_valid), 1);
        send(11'h297);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_count", 32'(bus.fifo_count), 0);
        check("mid_rst_valid", 32'(bus.data_valid), 0);
        check("mid_rst_data", 32'({bus.data_out, bus.data_perr, bus.data_ferr}), 0);
        repeat (2) tick();
        rst = 1'b1;
        bus.data_ready = 1'b1;
        repeat (4) tick();
        check("post_rst_valid", 32'(bus.data_valid), 0);
        check("post_rst_perr_cnt", 32'(bus.parity_err_cnt), 0);

        // Saturation: 300 parity errors
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back({8'h00, 1'b1, 1'b0});
            send(11'h297);
        end
        repeat (3) tick();
        check("sat_perr_cnt", 32'(bus.parity_err_cnt), 255);
        check("sat_ferr_cnt", 32'(bus.frame_err_cnt), 0);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
